dwc_precalc_cmd_slice: RTL
==========================

// Module: dwc_precalc_cmd_slice
// PURPOSE
//  Parametrised command pre-calculation slice for the DWC down-converter (AW or AR channel).
//  Accepts AXI4 address commands and computes the per-burst split fields needed by the command FIFO write controller.
//  Stores command plus fields in a DEPTH-entry register FIFO; DEPTH>=2 gives full throughput.
//  Adds illegal-command flagging (cmd_err) and exact WRAP lengths.
// PARAMETERS
//  DATA_WIDTH_IN   64  master-side data width, bits (power of 2, 32..512)
//  DATA_WIDTH_OUT  32  slave-side data width, bits (power of 2, <= DATA_WIDTH_IN)
//  ADDR_WIDTH      32  address width
//  ID_WIDTH         4  AxID width
//  USER_WIDTH       1  AxUSER width
//  WRITE_ENABLE     1  1 = write channel: FIXED-burst size_cnt/size_max use the lane offset
//  DEPTH            2  entries, 1..4
// PORTS
//  clk        in   1           clock
//  rst        in   1           asynchronous, active-low reset
//  s_a{len,valid,id,addr,burst,cache,lock,size,prot,qos,region,user}  in  AXI4 widths (len 8, lock 2)  upstream command
//  s_aready   out  1           registered, no combinational path from m_aready
//  m_a{len,id,addr,burst,cache,lock,size,prot,qos,region,user}  out  same widths  head-entry command
//  m_avalid   out  1           head entry valid
//  m_aready   in   1           head consumed by the write-control stage
//  addr_mux   out  ADDR_WIDTH  address, FIXED low bits aligned when sizes differ
//  to_boundary out 5  | mask_addr out 6 | asize out 3 | tot_len out 13 | max_len out 9
//  wrap_log_len out 3 | size_max out 6 | same_size out 1 | size_cnt out 6
//  fixed_burst out 1  | fixed_len_iter out 7 | cmd_err out 1 | occupancy out 3
// BEHAVIOUR
//  SO=log2(DW_OUT/8), MS=log2(DW_IN/8). Fields computed combinationally from s_a*; stored on push.
//  reduce=size>SO; asize=reduce?SO:size; sd=size-asize; fixed=(burst==2'b00); mask_addr=6'h3f<<asize.
//  lo=(addr[5:0]&((1<<size)-1))>>SO; foff=(addr[5:0]&((1<<MS)-1))>>SO.
//  to_boundary=(len+1)-((addr>>size)[3:0]&len[3:0]), 5-bit arithmetic.
//  tot_len=(reduce&&!fixed)?((len+1)<<sd)-lo : len+1, 13-bit.
//  max_len: INCR 9'h100; FIXED tot_len[8:0]; WRAP (len+1)<<sd.
//  wrap_log_len: len 1/3/7/15 -> 1/2/3/4, otherwise 0.
//  same_size=fixed?((((1<<sd)-1)==lo)||sd==0):(sd==0).
//  size_cnt=(fixed&&WE)?foff:((addr[5:0]&((1<<size)-1))>>asize).
//  size_max=(fixed&&WE)?foff+(1<<sd)-lo-1:(1<<sd)-1.
//  fixed_len_iter=(reduce&&fixed)?(1<<sd)-lo:1.
//  addr_mux=(fixed&&!same_size)?{addr[AW-1:6],addr[5:0]&mask_addr}:addr.
//  cmd_err=1 if burst==2'b11, size>MS, or WRAP with len not in {1,3,7,15}.
//    Errored commands still flow; the consumer decides.
//  push=s_avalid&&s_aready; pop=m_avalid&&m_aready; simultaneous push+pop keeps occupancy.
//  Latency: accepted cmd visible on m_* the next cycle when the FIFO was empty; FIFO order strictly preserved.
//  s_aready <= (occ_next<DEPTH). DEPTH=1 sustains 1 cmd / 2 cycles; DEPTH>=2 sustains 1 / cycle.
//  m_avalid=(occupancy!=0). m_* hold the last head when empty; values are deterministic but unused.
//  Pointers wrap modulo DEPTH. Push when full is impossible, because s_aready is low.
//  Reset (any time): occupancy=0, pointers=0, m_avalid=0, s_aready=0, all data outputs 0.
//    Stored entries are discarded. s_aready=1 on the first clk edge after release.
// STRUCTURE
//  dwc_pkg: BURST_FIXED/INCR/WRAP encodings, precalc field widths, fields struct typedef.
//  Sub-module dwc_precalc_comb: purely combinational field calculator.
//  Top: entry storage, pointers, occupancy, ready/valid logic.
// TESTING (DW_IN=64, DW_OUT=32, WE=1, DEPTH=2)
//  INCR len=3 size=3 addr=0x1004 -> asize=2, tot_len=7, max_len=256, size_cnt=1, size_max=1,
//    same_size=0, to_boundary=4, addr_mux=0x1004.
//  FIXED len=1 size=3 addr=0x2000 -> tot_len=2, max_len=2, same_size=0, fixed_len_iter=2,
//    size_max=1, addr_mux=0x2000. Same cmd at addr=0x2004 -> same_size=1, size_cnt=1, fixed_len_iter=1.
//  WRAP len=7 size=3 -> wrap_log_len=3, max_len=16, cmd_err=0.
//    WRAP len=5 -> wrap_log_len=0, cmd_err=1. burst=2'b11 -> cmd_err=1.
//  Three back-to-back cmds, m_aready=0 -> two accepted, s_aready=0.
//    m_aready=1 -> third accepted; outputs in A,B,C order; occupancy never exceeds 2.
//  Continuous s_avalid, m_aready=1 -> 1 cmd/cycle.
//    Same traffic with DEPTH=1 -> 1 cmd per 2 cycles.
//  rst asserted with occupancy=2 -> m_avalid=0 and outputs 0 immediately.
//    After release: s_aready=1 next edge; no stale command is replayed.

Source files
------------

// File: rtl/dwc_pkg.sv
// Shared definitions for the DWC command pre-calculation slice.
//   - AXI burst encodings
//   - widths of the per-burst split fields
//   - precalc_fields_t: the field bundle stored alongside each command
//   - wrap_log_len_of(): log2 of the beat count for legal WRAP lengths
package dwc_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam int TO_BOUNDARY_W = 5;
   localparam int MASK_ADDR_W   = 6;
   localparam int ASIZE_W       = 3;
   localparam int TOT_LEN_W     = 13;
   localparam int MAX_LEN_W     = 9;
   localparam int WRAP_LOG_W    = 3;
   localparam int SIZE_CNT_W    = 6;
   localparam int FIXED_ITER_W  = 7;
   localparam int OCC_W         = 3;

   typedef struct packed {
      logic [TO_BOUNDARY_W-1:0] to_boundary;
      logic [MASK_ADDR_W-1:0]   mask_addr;
      logic [ASIZE_W-1:0]       asize;
      logic [TOT_LEN_W-1:0]     tot_len;
      logic [MAX_LEN_W-1:0]     max_len;
      logic [WRAP_LOG_W-1:0]    wrap_log_len;
      logic [SIZE_CNT_W-1:0]    size_max;
      logic                     same_size;
      logic [SIZE_CNT_W-1:0]    size_cnt;
      logic                     fixed_burst;
      logic [FIXED_ITER_W-1:0]  fixed_len_iter;
      logic                     cmd_err;
   } precalc_fields_t;

   // 0 marks a length that is not a legal WRAP length.
   function automatic logic [WRAP_LOG_W-1:0] wrap_log_len_of(input logic [7:0] len);
      logic [WRAP_LOG_W-1:0] r;
      case (len)
         8'd1:    r = 3'd1;
         8'd3:    r = 3'd2;
         8'd7:    r = 3'd3;
         8'd15:   r = 3'd4;
         default: r = 3'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dwc_precalc_comb.sv
// Purely combinational split-field calculator for one AXI address command.
// Ports:
//   len, addr, burst, size  in   command fields used by the calculation
//   addr_mux                out  address, FIXED low bits aligned when sizes differ
//   fields                  out  per-burst split fields (precalc_fields_t)
module dwc_precalc_comb
   import dwc_pkg::*;
#(
   parameter int DATA_WIDTH_IN  = 64,
   parameter int DATA_WIDTH_OUT = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int WRITE_ENABLE   = 1
) (
   input  logic [7:0]            len,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [1:0]            burst,
   input  logic [2:0]            size,
   output logic [ADDR_WIDTH-1:0] addr_mux,
   output precalc_fields_t       fields
);

   localparam int SO = $clog2(DATA_WIDTH_OUT / 8);
   localparam int MS = $clog2(DATA_WIDTH_IN / 8);
   localparam logic [5:0] MS_MASK = 6'((7'd1 << MS) - 7'd1);

   logic        reduce, fixed, wrap, we_fixed, same_size;
   logic [2:0]  asize, sd, wrap_log;
   logic [5:0]  off, lo, foff, mask_addr;
   logic [7:0]  sd_pow;
   logic [8:0]  len1;
   logic [3:0]  beat;
   logic [12:0] tot_len;

   assign reduce   = size > 3'(SO);
   assign asize    = reduce ? 3'(SO) : size;
   assign sd       = size - asize;
   assign sd_pow   = 8'd1 << sd;
   assign fixed    = (burst == BURST_FIXED);
   assign wrap     = (burst == BURST_WRAP);
   assign we_fixed = fixed && (WRITE_ENABLE != 0);
   assign len1     = {1'b0, len} + 9'd1;

   // Byte offset inside the master beat, then expressed in slave beats.
   assign off  = addr[5:0] & 6'((8'd1 << size) - 8'd1);
   assign lo   = off >> SO;
   // Lane offset inside the full master data width (write-side FIXED).
   assign foff = (addr[5:0] & MS_MASK) >> SO;

   // Beat index of the start address inside a 16-beat window.
   assign beat = 4'(addr >> size);

   assign tot_len   = (reduce && !fixed) ? 13'(({4'b0, len1} << sd) - {7'b0, lo})
                                         : {4'b0, len1};
   assign wrap_log  = wrap_log_len_of(len);
   assign same_size = fixed ? (({2'b0, lo} == (sd_pow - 8'd1)) || (sd == 3'd0))
                            : (sd == 3'd0);
   assign mask_addr = 6'h3f << asize;

   assign fields.to_boundary    = 5'(len1[4:0] - {1'b0, beat & len[3:0]});
   assign fields.mask_addr      = mask_addr;
   assign fields.asize          = asize;
   assign fields.tot_len        = tot_len;
   assign fields.max_len        = wrap  ? 9'(len1 << sd) :
                                  fixed ? tot_len[8:0]   : 9'h100;
   assign fields.wrap_log_len   = wrap_log;
   assign fields.size_max       = we_fixed ? 6'({2'b0, foff} + sd_pow - {2'b0, lo} - 8'd1)
                                           : 6'(sd_pow - 8'd1);
   assign fields.same_size      = same_size;
   assign fields.size_cnt       = we_fixed ? foff : (off >> asize);
   assign fields.fixed_burst    = fixed;
   assign fields.fixed_len_iter = (reduce && fixed) ? 7'(sd_pow - {2'b0, lo}) : 7'd1;
   // Illegal commands are only flagged; they still travel downstream.
   assign fields.cmd_err        = (burst == BURST_RSVD) || (size > 3'(MS)) ||
                                  (wrap && (wrap_log == 3'd0));

   assign addr_mux = (fixed && !same_size) ? {addr[ADDR_WIDTH-1:6], addr[5:0] & mask_addr}
                                           : addr;

endmodule

// File: rtl/dwc_precalc_cmd_slice.sv
// Command pre-calculation slice for the DWC down-converter (AW or AR).
// Computes the split fields of each accepted command and queues command plus
// fields in a DEPTH-entry register FIFO.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   s_a*                  upstream AXI4 address command (s_aready registered)
//   m_a*, m_avalid        head-entry command / valid
//   m_aready              head consumed downstream
//   addr_mux .. cmd_err   head-entry precalculated fields
//   occupancy             number of stored entries
module dwc_precalc_cmd_slice
   import dwc_pkg::*;
#(
   parameter int DATA_WIDTH_IN  = 64,
   parameter int DATA_WIDTH_OUT = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int ID_WIDTH       = 4,
   parameter int USER_WIDTH     = 1,
   parameter int WRITE_ENABLE   = 1,
   parameter int DEPTH          = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            s_alen,
   input  logic                  s_avalid,
   input  logic [ID_WIDTH-1:0]   s_aid,
   input  logic [ADDR_WIDTH-1:0] s_aaddr,
   input  logic [1:0]            s_aburst,
   input  logic [3:0]            s_acache,
   input  logic [1:0]            s_alock,
   input  logic [2:0]            s_asize,
   input  logic [2:0]            s_aprot,
   input  logic [3:0]            s_aqos,
   input  logic [3:0]            s_aregion,
   input  logic [USER_WIDTH-1:0] s_auser,
   output logic                  s_aready,
   output logic [7:0]            m_alen,
   output logic [ID_WIDTH-1:0]   m_aid,
   output logic [ADDR_WIDTH-1:0] m_aaddr,
   output logic [1:0]            m_aburst,
   output logic [3:0]            m_acache,
   output logic [1:0]            m_alock,
   output logic [2:0]            m_asize,
   output logic [2:0]            m_aprot,
   output logic [3:0]            m_aqos,
   output logic [3:0]            m_aregion,
   output logic [USER_WIDTH-1:0] m_auser,
   output logic                  m_avalid,
   input  logic                  m_aready,
   output logic [ADDR_WIDTH-1:0] addr_mux,
   output logic [4:0]            to_boundary,
   output logic [5:0]            mask_addr,
   output logic [2:0]            asize,
   output logic [12:0]           tot_len,
   output logic [8:0]            max_len,
   output logic [2:0]            wrap_log_len,
   output logic [5:0]            size_max,
   output logic                  same_size,
   output logic [5:0]            size_cnt,
   output logic                  fixed_burst,
   output logic [6:0]            fixed_len_iter,
   output logic                  cmd_err,
   output logic [2:0]            occupancy
);

   localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SLOTS   = 2 ** PW;
   localparam int CMD_W   = 8 + ID_WIDTH + ADDR_WIDTH + 2 + 4 + 2 + 3 + 3 + 4 + 4 + USER_WIDTH;
   localparam int ENTRY_W = CMD_W + ADDR_WIDTH + $bits(precalc_fields_t);

   logic [ADDR_WIDTH-1:0] calc_addr_mux;
   precalc_fields_t       calc_fields, head_fields;
   logic [ENTRY_W-1:0]    entry_in, head;
   logic [ENTRY_W-1:0]    mem_reg [SLOTS];
   logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg, last_ptr_reg, head_sel;
   logic [OCC_W-1:0]      occupancy_reg, occ_next;
   logic                  s_aready_reg, push, pop;

   dwc_precalc_comb #(
      .DATA_WIDTH_IN  (DATA_WIDTH_IN),
      .DATA_WIDTH_OUT (DATA_WIDTH_OUT),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .WRITE_ENABLE   (WRITE_ENABLE)
   ) u_calc (
      .len      (s_alen),
      .addr     (s_aaddr),
      .burst    (s_aburst),
      .size     (s_asize),
      .addr_mux (calc_addr_mux),
      .fields   (calc_fields)
   );

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign push     = s_avalid && s_aready_reg;
   assign pop      = m_avalid && m_aready;
   assign occ_next = occupancy_reg + {2'b00, push} - {2'b00, pop};

   assign entry_in = {s_alen, s_aid, s_aaddr, s_aburst, s_acache, s_alock, s_asize,
                      s_aprot, s_aqos, s_aregion, s_auser, calc_addr_mux, calc_fields};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SLOTS; i++) mem_reg[i] <= '0;
      end else if (push) begin
         mem_reg[wr_ptr_reg] <= entry_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         last_ptr_reg  <= '0;
         occupancy_reg <= '0;
         s_aready_reg  <= 1'b0;
      end else begin
         occupancy_reg <= occ_next;
         // Ready depends only on local state, so m_aready never reaches s_aready combinationally.
         s_aready_reg  <= (occ_next < OCC_W'(DEPTH));
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop) begin
            last_ptr_reg <= rd_ptr_reg;
            rd_ptr_reg   <= ptr_inc(rd_ptr_reg);
         end
      end
   end

   // When empty, keep presenting the entry that was popped last rather than a
   // stale older slot, so the outputs stay at the last head.
   assign head_sel = (occupancy_reg == '0) ? last_ptr_reg : rd_ptr_reg;
   assign head     = mem_reg[head_sel];

   assign {m_alen, m_aid, m_aaddr, m_aburst, m_acache, m_alock, m_asize,
           m_aprot, m_aqos, m_aregion, m_auser, addr_mux, head_fields} = head;

   assign to_boundary    = head_fields.to_boundary;
   assign mask_addr      = head_fields.mask_addr;
   assign asize          = head_fields.asize;
   assign tot_len        = head_fields.tot_len;
   assign max_len        = head_fields.max_len;
   assign wrap_log_len   = head_fields.wrap_log_len;
   assign size_max       = head_fields.size_max;
   assign same_size      = head_fields.same_size;
   assign size_cnt       = head_fields.size_cnt;
   assign fixed_burst    = head_fields.fixed_burst;
   assign fixed_len_iter = head_fields.fixed_len_iter;
   assign cmd_err        = head_fields.cmd_err;

   assign s_aready  = s_aready_reg;
   assign m_avalid  = (occupancy_reg != '0);
   assign occupancy = occupancy_reg;

endmodule
